// File: rtl/param_updown_counter_if.sv
// Control/status bundle for param_updown_counter: master drives the controls, slave (the counter) drives the count and flags.
interface param_updown_counter_if #(
    parameter int DATA_WIDTH = 16,
    parameter int STEP_WIDTH = 4
);
    logic                  clear;
    logic                  en;
    logic                  load;
    logic [DATA_WIDTH-1:0] d;
    logic                  up_down;
    logic [STEP_WIDTH-1:0] step;
    logic [DATA_WIDTH-1:0] cmp;
    logic [DATA_WIDTH-1:0] qd;
    logic                  at_max;
    logic                  at_min;
    logic                  match;
    logic                  wrap_pulse;
    logic                  sat_pulse;

    modport master (
        output clear, en, load, d, up_down, step, cmp,
        input  qd, at_max, at_min, match, wrap_pulse, sat_pulse
    );

    modport slave (
        input  clear, en, load, d, up_down, step, cmp,
        output qd, at_max, at_min, match, wrap_pulse, sat_pulse
    );
endinterface

// File: rtl/param_updown_counter.sv
// Bounded up/down counter with wrap or saturate, clamped load, bound/compare flags and one-cycle event pulses.
// Latency: qd and pulses update one cycle after the sampling edge; no backpressure, accepts controls every cycle.
module param_updown_counter #(
    parameter int              DATA_WIDTH  = 16,
    parameter int              STEP_WIDTH  = 4,
    parameter longint unsigned MIN_VALUE   = 0,
    parameter longint unsigned MAX_VALUE   = (DATA_WIDTH >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF
                                                                : ((64'd1 << DATA_WIDTH) - 64'd1),
    parameter longint unsigned RESET_VALUE = MIN_VALUE,
    parameter bit              SATURATE    = 1'b0
) (
    input logic                 clk,
    input logic                 rst,
    param_updown_counter_if.slave bus
);
    localparam int XW = DATA_WIDTH + 1;
    typedef logic [XW-1:0]         ext_t;
    typedef logic [DATA_WIDTH-1:0] cnt_t;

    localparam ext_t MIN_X   = ext_t'(MIN_VALUE);
    localparam ext_t MAX_X   = ext_t'(MAX_VALUE);
    localparam ext_t ONE_X   = ext_t'(1);
    localparam ext_t RANGE_X = MAX_X - MIN_X + ONE_X;
    localparam cnt_t MIN_D   = cnt_t'(MIN_VALUE);
    localparam cnt_t MAX_D   = cnt_t'(MAX_VALUE);
    localparam cnt_t RST_D   = cnt_t'(RESET_VALUE);

    if (DATA_WIDTH < 2 || DATA_WIDTH > 64) begin : g_bad_width
        $fatal(1, "param_updown_counter: DATA_WIDTH must be 2..64");
    end
    if (!(MIN_VALUE < MAX_VALUE)) begin : g_bad_order
        $fatal(1, "param_updown_counter: MIN_VALUE must be below MAX_VALUE");
    end
    if (RESET_VALUE < MIN_VALUE || RESET_VALUE > MAX_VALUE) begin : g_bad_reset
        $fatal(1, "param_updown_counter: RESET_VALUE outside [MIN_VALUE, MAX_VALUE]");
    end
    if (DATA_WIDTH < 64 && (MAX_VALUE >> DATA_WIDTH) != 64'd0) begin : g_bad_max
        $fatal(1, "param_updown_counter: MAX_VALUE does not fit in DATA_WIDTH");
    end

    cnt_t qd_r, qd_nxt, d_clamp;
    logic wrap_r, wrap_nxt, sat_r, sat_nxt;
    ext_t qd_x, step_x, sum_x, deficit_x;
    logic over_up, under_dn;

    // One extra bit keeps qd+step and MIN+step exact, so overflow tests never alias.
    assign qd_x      = {1'b0, qd_r};
    assign step_x    = ext_t'(bus.step);
    assign sum_x     = qd_x + step_x;
    assign over_up   = sum_x > MAX_X;
    assign under_dn  = (MIN_X + step_x) > qd_x;
    assign deficit_x = MIN_X + step_x - qd_x - ONE_X;

    always_comb begin
        d_clamp = bus.d;
        if (bus.d < MIN_D) begin
            d_clamp = MIN_D;
        end else if (bus.d > MAX_D) begin
            d_clamp = MAX_D;
        end
    end

    always_comb begin
        qd_nxt   = qd_r;
        wrap_nxt = 1'b0;
        sat_nxt  = 1'b0;
        if (!bus.clear) begin
            qd_nxt = MIN_D;
        end else if (bus.load) begin
            qd_nxt = d_clamp;
        end else if (bus.en) begin
            if (bus.up_down) begin
                if (!over_up) begin
                    qd_nxt = cnt_t'(sum_x);
                end else if (SATURATE) begin
                    qd_nxt  = MAX_D;
                    sat_nxt = 1'b1;
                end else begin
                    qd_nxt   = cnt_t'(MIN_X + (sum_x - MAX_X - ONE_X));
                    wrap_nxt = 1'b1;
                end
            end else begin
                if (!under_dn) begin
                    qd_nxt = cnt_t'(qd_x - step_x);
                end else if (SATURATE) begin
                    qd_nxt  = MIN_D;
                    sat_nxt = 1'b1;
                end else begin
                    qd_nxt   = cnt_t'(MAX_X - deficit_x);
                    wrap_nxt = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            qd_r   <= RST_D;
            wrap_r <= 1'b0;
            sat_r  <= 1'b0;
        end else begin
            qd_r   <= qd_nxt;
            wrap_r <= wrap_nxt;
            sat_r  <= sat_nxt;
        end
    end

    assign bus.qd         = qd_r;
    assign bus.at_max     = (qd_r == MAX_D);
    assign bus.at_min     = (qd_r == MIN_D);
    assign bus.match      = (qd_r == bus.cmp);
    assign bus.wrap_pulse = wrap_r;
    assign bus.sat_pulse  = sat_r;

    // A step larger than the whole range would wrap more than once; the result is meaningless.
    a_step_range: assert property (@(posedge clk) disable iff (rst)
        (bus.clear && !bus.load && bus.en) |-> (step_x <= RANGE_X))
        else $error("param_updown_counter: step exceeds count range");
endmodule

// File: tb/tb_param_updown_counter.sv
// Directed bench: one wrap-mode and one saturate-mode counter (range 10..200) driven with identical controls.
module tb_param_updown_counter;
    localparam int DW = 8;
    localparam int SW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    param_updown_counter_if #(.DATA_WIDTH(DW), .STEP_WIDTH(SW)) bw ();
    param_updown_counter_if #(.DATA_WIDTH(DW), .STEP_WIDTH(SW)) bs ();

    param_updown_counter #(
        .DATA_WIDTH(DW), .STEP_WIDTH(SW), .MIN_VALUE(10), .MAX_VALUE(200),
        .RESET_VALUE(10), .SATURATE(1'b0)
    ) u_wrap (.clk(clk), .rst(rst), .bus(bw));

    param_updown_counter #(
        .DATA_WIDTH(DW), .STEP_WIDTH(SW), .MIN_VALUE(10), .MAX_VALUE(200),
        .RESET_VALUE(10), .SATURATE(1'b1)
    ) u_sat (.clk(clk), .rst(rst), .bus(bs));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic clr, input logic ld, input logic [DW-1:0] dv,
                         input logic e, input logic ud, input logic [SW-1:0] st);
        bw.clear = clr; bw.load = ld; bw.d = dv; bw.en = e; bw.up_down = ud; bw.step = st; bw.cmp = 8'd20;
        bs.clear = clr; bs.load = ld; bs.d = dv; bs.en = e; bs.up_down = ud; bs.step = st; bs.cmp = 8'd20;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // sel: 0 = wrap instance, 1 = saturate instance
    task automatic chk(input string tag, input bit sel, input logic [DW-1:0] q,
                       input logic wp, input logic sp);
        if (sel) begin
            check({tag, "_qd"},   bs.qd, q);
            check({tag, "_wrap"}, bs.wrap_pulse, wp);
            check({tag, "_sat"},  bs.sat_pulse, sp);
        end else begin
            check({tag, "_qd"},   bw.qd, q);
            check({tag, "_wrap"}, bw.wrap_pulse, wp);
            check({tag, "_sat"},  bw.sat_pulse, sp);
        end
    endtask

    initial begin
        drive(1'b1, 1'b0, 8'd0, 1'b0, 1'b1, 4'd0);
        repeat (2) tick();
        chk("rst_w", 1'b0, 8'd10, 1'b0, 1'b0);
        chk("rst_s", 1'b1, 8'd10, 1'b0, 1'b0);
        check("rst_at_min", bw.at_min, 1'b1);
        check("rst_at_max", bw.at_max, 1'b0);
        rst = 1'b0;
        tick();
        chk("rel_hold", 1'b0, 8'd10, 1'b0, 1'b0);

        // Test 1: async reset mid-count at 57
        drive(1'b1, 1'b1, 8'd52, 1'b0, 1'b1, 4'd0);
        tick();
        chk("ld52", 1'b0, 8'd52, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 8'd0, 1'b1, 1'b1, 4'd5);
        tick();
        chk("cnt57", 1'b0, 8'd57, 1'b0, 1'b0);
        #3 rst = 1'b1;
        #1;
        check("async_rst_w", bw.qd, 8'd10);
        check("async_rst_s", bs.qd, 8'd10);
        drive(1'b1, 1'b0, 8'd0, 1'b0, 1'b1, 4'd0);
        rst = 1'b0;
        tick();
        chk("post_rst", 1'b0, 8'd10, 1'b0, 1'b0);
        check("post_rst_at_min", bw.at_min, 1'b1);
        check("post_rst_at_max", bw.at_max, 1'b0);

        // Tests 2 and 4: up past MAX from 198, step 5, two enabled cycles
        drive(1'b1, 1'b1, 8'd198, 1'b0, 1'b1, 4'd0);
        tick();
        chk("ld198", 1'b0, 8'd198, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 8'd0, 1'b1, 1'b1, 4'd5);
        tick();
        chk("wrap_up1", 1'b0, 8'd12, 1'b1, 1'b0);
        chk("sat_up1",  1'b1, 8'd200, 1'b0, 1'b1);
        check("sat_up1_at_max", bs.at_max, 1'b1);
        tick();
        chk("wrap_up2", 1'b0, 8'd17, 1'b0, 1'b0);
        chk("sat_up2",  1'b1, 8'd200, 1'b0, 1'b1);
        check("sat_up2_at_max", bs.at_max, 1'b1);
        drive(1'b1, 1'b0, 8'd0, 1'b0, 1'b1, 4'd5);
        tick();
        chk("sat_idle", 1'b1, 8'd200, 1'b0, 1'b0);

        // Test 3: down past MIN from 11, step 3
        drive(1'b1, 1'b1, 8'd11, 1'b0, 1'b0, 4'd0);
        tick();
        drive(1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 4'd3);
        tick();
        chk("wrap_dn", 1'b0, 8'd199, 1'b1, 1'b0);
        chk("sat_dn",  1'b1, 8'd10, 1'b0, 1'b1);
        check("sat_dn_at_min", bs.at_min, 1'b1);
        drive(1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 4'd3);
        tick();
        chk("wrap_dn_idle", 1'b0, 8'd199, 1'b0, 1'b0);

        // Exact landing on MAX is neither wrap nor clamp
        drive(1'b1, 1'b1, 8'd195, 1'b0, 1'b1, 4'd0);
        tick();
        drive(1'b1, 1'b0, 8'd0, 1'b1, 1'b1, 4'd5);
        tick();
        chk("land_w", 1'b0, 8'd200, 1'b0, 1'b0);
        chk("land_s", 1'b1, 8'd200, 1'b0, 1'b0);
        check("land_at_max", bw.at_max, 1'b1);

        // Test 5: priority and load clamping
        drive(1'b0, 1'b1, 8'd100, 1'b1, 1'b1, 4'd5);
        tick();
        chk("clr_wins", 1'b0, 8'd10, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 8'd250, 1'b1, 1'b1, 4'd5);
        tick();
        chk("ld_hi_w", 1'b0, 8'd200, 1'b0, 1'b0);
        chk("ld_hi_s", 1'b1, 8'd200, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 8'd3, 1'b0, 1'b1, 4'd0);
        tick();
        chk("ld_lo", 1'b0, 8'd10, 1'b0, 1'b0);

        // Test 6: compare match and step 0
        check("match_10", bw.match, 1'b0);
        drive(1'b1, 1'b0, 8'd0, 1'b1, 1'b1, 4'd5);
        tick();
        check("match_15", bw.match, 1'b0);
        tick();
        check("qd_20", bw.qd, 8'd20);
        check("match_20", bw.match, 1'b1);
        tick();
        check("match_25", bw.match, 1'b0);
        drive(1'b1, 1'b0, 8'd0, 1'b1, 1'b1, 4'd0);
        tick();
        chk("step0_w", 1'b0, 8'd25, 1'b0, 1'b0);
        chk("step0_s", 1'b1, 8'd25, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/param_updown_counter.md
Name: param_updown_counter

Overview:
Parametrised successor to the team's fixed 8-bit load/clear up/down counter. It generalises width, bounds and step size, and adds wrap or saturate mode, range-clamped load, terminal-count flags, a compare match and one-cycle boundary event pulses. It is used as the generic counter primitive for timers, address generators and credit counters across the design.

Parameters:
- DATA_WIDTH, 16, counter and load width in bits (2..64).
- STEP_WIDTH, 4, width of the per-cycle step input.
- MIN_VALUE, 0, lower bound of the count range.
- MAX_VALUE, 2**DATA_WIDTH-1, upper bound of the count range. Must satisfy MIN_VALUE < MAX_VALUE.
- RESET_VALUE, MIN_VALUE, value of qd after rst. Must lie in [MIN_VALUE, MAX_VALUE].
- SATURATE, 0, boundary mode: 0 = wrap, 1 = saturate.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- clear  in  1  synchronous clear, active-low; loads MIN_VALUE.
- en  in  1  count enable.
- load  in  1  synchronous load of d.
- d  in  DATA_WIDTH  load value.
- up_down  in  1  count direction: 1 = up, 0 = down.
- step  in  STEP_WIDTH  increment or decrement amount per enabled cycle.
- cmp  in  DATA_WIDTH  compare value.
- qd  out  DATA_WIDTH  registered count.
- at_max  out  1  qd == MAX_VALUE (combinational from qd).
- at_min  out  1  qd == MIN_VALUE (combinational from qd).
- match  out  1  qd == cmp (combinational).
- wrap_pulse  out  1  registered; high for one cycle after a wrap.
- sat_pulse  out  1  registered; high for one cycle after a clamp.

Behaviour:
- Reset: rst high forces, asynchronously, qd = RESET_VALUE, wrap_pulse = 0, sat_pulse = 0. Release is synchronous to clk; the first update occurs on the first rising edge after rst falls.
- Priority, evaluated per rising edge: rst > !clear > load > en > hold.
- clear = 0: qd <= MIN_VALUE; both pulses <= 0.
- load = 1: qd <= d clamped to [MIN_VALUE, MAX_VALUE]; both pulses <= 0. Clamping is silent; sat_pulse is not raised.
- en = 1 with no load and no clear: qd is updated with step in direction up_down. Arithmetic is done at DATA_WIDTH+1 bits so that no intermediate overflow is lost.
- Up count, qd + step > MAX_VALUE:
  - Wrap mode: qd <= MIN_VALUE + (qd + step - MAX_VALUE - 1); wrap_pulse <= 1.
  - Saturate mode: qd <= MAX_VALUE; sat_pulse <= 1.
- Down count, qd - step < MIN_VALUE:
  - Wrap mode: qd <= MAX_VALUE - (MIN_VALUE - (qd - step) - 1); wrap_pulse <= 1.
  - Saturate mode: qd <= MIN_VALUE; sat_pulse <= 1.
- Exact landing on a bound (for example qd + step == MAX_VALUE) is neither a wrap nor a clamp; no pulse is raised.
- Saturate mode already at a bound: counting further into that bound holds qd and still raises sat_pulse for that cycle.
- step = 0 with en = 1: qd holds; no pulse.
- Step range constraint: step must be <= MAX_VALUE - MIN_VALUE + 1. A simulation-only assertion flags a violation. qd is undefined in that case.
- en = 0 (no load, no clear): qd holds; both pulses <= 0. Pulses last exactly one cycle unless the triggering event repeats on the next cycle.
- Simultaneous load and en: load wins; no count happens that cycle.
- Elaboration-time checks: MIN_VALUE < MAX_VALUE, RESET_VALUE in range, MAX_VALUE < 2**DATA_WIDTH. Any failure is a fatal error.
- Latency: qd reflects a load, clear or count one cycle after the sampling edge. at_max, at_min and match follow qd in the same cycle.
- Reset mid-operation: all state is discarded immediately; in-flight pulses clear to 0.

Test Plan:
Common configuration: DATA_WIDTH = 8, MIN_VALUE = 10, MAX_VALUE = 200, RESET_VALUE = 10.
1. Reset and hold: assert rst mid-count at qd = 57 -> qd = 10 with no clock edge; release rst with en = 0 -> qd stays 10; at_min = 1, at_max = 0.
2. Wrap up (SATURATE = 0): load d = 198, then en = 1, up_down = 1, step = 5 -> qd = 12 the next cycle; wrap_pulse = 1 for exactly one cycle.
3. Wrap down (SATURATE = 0): load d = 11, then en = 1, up_down = 0, step = 3 -> qd = 199; wrap_pulse = 1.
4. Saturate (SATURATE = 1): load d = 198, then en = 1, up_down = 1, step = 5 for two cycles -> qd = 200 both cycles; sat_pulse = 1 both cycles; at_max = 1. Landing exactly: from 195 with step = 5 -> qd = 200, sat_pulse = 0.
5. Priority and clamping:
   - clear = 0, load = 1, en = 1 on the same edge -> qd = 10.
   - load = 1, d = 250, en = 1 -> qd = 200, no pulse.
   - load = 1, d = 3 -> qd = 10.
6. Compare and step 0: cmp = 20, count up from 10 with step = 5 -> match high only while qd = 20. step = 0 with en = 1 -> qd unchanged, no pulse.
